// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: valid/ready handshake, flush bubble, valid-gated memory strobes, saturating stall counter.
// Define EX_MEM_SKID_EN to add a second (skid) entry so that in_ready comes straight from a register.
module ex_mem_stage #(
  parameter int DW    = 32,
  parameter int WB_W  = 2,
  parameter int MEM_W = 4,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  input  logic [WB_W-1:0]  WB_in,
  output logic [WB_W-1:0]  WB_out,
  input  logic [MEM_W-1:0] MEM_in,
  output logic [MEM_W-1:0] MEM_out,
  input  logic [DW-1:0]    nextAddress_in,
  output logic [DW-1:0]    nextAddress_out,
  input  logic             zero_in,
  output logic             zero_out,
  input  logic [DW-1:0]    ALUresult_in,
  output logic [DW-1:0]    ALUresult_out,
  input  logic [DW-1:0]    B_in,
  output logic [DW-1:0]    B_out,
  input  logic [RA_W-1:0]  Insaddr_in,
  output logic [RA_W-1:0]  Insaddr_out,
  input  logic [DW-1:0]    jaddr_in,
  output logic [DW-1:0]    jaddr_out,
  output logic             jump,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = WB_W + MEM_W + 4 * DW + 1 + RA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]    w_pay_in;
  logic [PW-1:0]    r_main;
  logic             r_main_valid;
  logic             w_accept;
  logic             w_consume;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [3:0]       w_strobe;

  assign w_pay_in  = {WB_in, MEM_in, nextAddress_in, zero_in, ALUresult_in, B_in, Insaddr_in, jaddr_in};
  assign w_consume = r_main_valid & out_ready;
  assign w_accept  = in_valid & in_ready & ~flush;

`ifdef EX_MEM_SKID_EN
  logic [PW-1:0] r_skid;
  logic          r_skid_valid;

  assign in_ready = ~r_skid_valid;

  // Skid is only ever occupied while main is full, so draining skid first keeps order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_consume || !r_main_valid) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_pay_in;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid       <= w_pay_in;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = ~r_main_valid | out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
    end else if (w_accept) begin
      r_main       <= w_pay_in;
      r_main_valid <= 1'b1;
    end else if (w_consume) begin
      r_main_valid <= 1'b0;
    end
  end
`endif

  // Counts backpressure cycles; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (r_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign {WB_out, MEM_out, nextAddress_out, zero_out, ALUresult_out, B_out, Insaddr_out, jaddr_out} = r_main;
  assign out_valid = r_main_valid;
  assign stall_cnt = r_stall_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strobe
      assign w_strobe[gi] = MEM_out[gi] & r_main_valid;
    end
  endgenerate

  assign MemWrite = w_strobe[0];
  assign MemRead  = w_strobe[1];
  assign Branch   = w_strobe[2];
  assign jump     = w_strobe[3];

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Parametrised EX/MEM pipeline stage, successor to the fixed-width EX/MEM register. It carries the WB/MEM control fields, next PC, zero flag, ALU result, store data, destination register and jump target from EX to MEM. It adds a valid/ready handshake, a flush that inserts a bubble, decoded memory strobes gated by valid, and a saturating stall counter. It sits between the ALU stage and the data-memory/branch-resolution logic.

## Interface
- DW, 32, width of nextAddress, ALUresult, B and jaddr
- WB_W, 2, width of the WB control field
- MEM_W, 4, width of the MEM control field (≥4); bits [3:0] = jump, Branch, MemRead, MemWrite
- RA_W, 5, destination-register address width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- in_valid  in  1  EX presents a valid entry
- in_ready  out  1  stage can accept this cycle
- out_valid  out  1  MEM-side entry valid
- out_ready  in  1  MEM consumes the entry this cycle
- flush  in  1  discard all held and incoming entries
- WB_in / WB_out  in/out  WB_W  writeback control
- MEM_in / MEM_out  in/out  MEM_W  memory control, raw
- nextAddress_in / nextAddress_out  in/out  DW  PC+4
- zero_in / zero_out  in/out  1  ALU zero flag
- ALUresult_in / ALUresult_out  in/out  DW  ALU result or address
- B_in / B_out  in/out  DW  store data
- Insaddr_in / Insaddr_out  in/out  RA_W  destination register
- jaddr_in / jaddr_out  in/out  DW  jump target
- jump, Branch, MemRead, MemWrite  out  1 each  MEM_out[3..0] AND out_valid
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Accept when in_valid & in_ready & !flush. Present/consume when out_valid & out_ready.
- The payload is all *_in fields, captured together into the main register on accept when the main register is empty or is being consumed.
- Payload outputs change only when a new entry loads. Otherwise they hold, including across a flush and while out_valid=0.
- The decoded strobes are always gated by out_valid. A bubble never asserts MemWrite, MemRead, Branch or jump.
- flush=1: out_valid (and skid valid) become 0 at the next edge. The input that cycle is discarded even if in_valid=1. Flush overrides accept and consume. in_ready is unaffected combinationally.
- stall_cnt increments by 1 each cycle with out_valid & !out_ready, and saturates at 2^CNT_W−1. Only reset clears it; flush does not.

## Timing
- Latency is 1 cycle from accept to out_valid=1.
- Full throughput: one entry per cycle when out_ready=1.
- Reset values: out_valid=0, every payload output 0, all strobes 0, stall_cnt=0, in_ready=1.
- Reset asserted mid-transfer drops the entry; no partial state remains.
- Without a skid buffer, in_ready = !out_valid | out_ready. This is a combinational path from out_ready.

## Configuration
- EX_MEM_SKID_EN defined:
  - A second payload register (skid) is added. in_ready = !skid_valid, driven from a register, so there is no path from out_ready.
  - An entry accepted while the main register is full and not consumed goes to skid.
  - When main is consumed, skid moves to main (or the new input does, if skid is empty).
  - Order is strictly preserved. Capacity is 2 entries.
- EX_MEM_SKID_EN undefined: single register, combinational in_ready as above, capacity 1.

## Test plan
- Reset with every input nonzero, reset=0 → all outputs 0 and in_ready=1. Release reset, accept ALUresult=0x1234 with MEM_in=4'b0001 → next cycle out_valid=1, MemWrite=1, ALUresult_out=0x1234.
- Stream 8 entries (ALUresult=1..8) with out_ready=1 → outputs 1..8 on consecutive cycles, no gaps, stall_cnt=0.
- Hold out_ready=0 for 5 cycles with an entry valid → payload stable and stall_cnt=5. Without skid, in_ready=0. With skid, the second entry is accepted, then in_ready=0. On release both drain in order.
- flush while valid with MEM_in=4'b0011 and in_valid=1 → next cycle out_valid=0, MemWrite=MemRead=0, incoming entry lost, ALUresult_out unchanged.
- CNT_W=4, out_ready=0 for 20 cycles → stall_cnt saturates at 15. Asserting flush leaves it at 15.
- Assert reset asynchronously between edges while skid holds an entry → outputs clear before the next edge. After release, out_valid=0.
